// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one byte-addressable data memory between the CPU
// load/store port (m0) and the UART loader/debug port (m1). Round-robin
// arbitration with a bounded lock, two-cycle read-modify-write for partial
// stores, and error responses for misaligned or out-of-range addresses.
module dmem_arbiter #(
    parameter int DEPTH_BYTES = 64,
    parameter int LOCK_MAX    = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_err,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_err,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(LOCK_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [31:0]      MAX_ADDR = 32'(DEPTH_BYTES - 4);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             last;
    logic             owner;
    logic             owned;
    logic [CNT_W-1:0] lock_cnt;
    logic [31:0]      merge;
    logic             rmw_id;

    logic             owner_req;
    logic             lock_active;
    logic             sel_valid;
    logic             sel_id;
    logic             cur_id;
    logic             s_we;
    logic             s_lock;
    logic [31:0]      s_addr;
    logic [31:0]      s_wdata;
    logic [3:0]       s_be;
    logic             s_err;
    logic             s_partial;
    logic [31:0]      merge_next;
    logic             gnt_int;
    logic             err_int;
    logic             rd_grant;

    // Pick the master to serve in IDLE: a live lock owner first, then round-robin.
    always_comb begin
        owner_req   = owner ? m1_req : m0_req;
        lock_active = owned && owner_req && (lock_cnt < CNT_MAX);
        sel_valid   = 1'b0;
        sel_id      = 1'b0;
        if (lock_active) begin
            sel_valid = 1'b1;
            sel_id    = owner;
        end else if (m0_req && m1_req) begin
            sel_valid = 1'b1;
            sel_id    = ~last;
        end else if (m0_req) begin
            sel_valid = 1'b1;
            sel_id    = 1'b0;
        end else if (m1_req) begin
            sel_valid = 1'b1;
            sel_id    = 1'b1;
        end
    end

    // Route the current master's request fields and classify the access; the RMW master's inputs stay stable until its grant.
    always_comb begin
        cur_id    = (state == RMW_WR) ? rmw_id : sel_id;
        s_we      = cur_id ? m1_we    : m0_we;
        s_lock    = cur_id ? m1_lock  : m0_lock;
        s_addr    = cur_id ? m1_addr  : m0_addr;
        s_wdata   = cur_id ? m1_wdata : m0_wdata;
        s_be      = cur_id ? m1_be    : m0_be;
        s_err     = (s_addr[1:0] != 2'b00) || (s_addr > MAX_ADDR);
        s_partial = s_we && !s_err && (s_be != 4'hF) && (s_be != 4'h0);
        for (int k = 0; k < 4; k++) begin
            merge_next[8*k +: 8] = s_be[k] ? s_wdata[8*k +: 8] : mem_rdata[8*k +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a partial store detours through RMW_WR for its write half.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sel_valid && s_partial) state_next = RMW_WR;
            RMW_WR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes and grant/error responses, all held low during reset.
    always_comb begin
        gnt_int   = 1'b0;
        err_int   = 1'b0;
        rd_grant  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        if (s_err) begin
                            gnt_int = 1'b1;
                            err_int = 1'b1;
                        end else if (!s_we) begin
                            mem_addr = s_addr;
                            mem_read = 1'b1;
                            gnt_int  = 1'b1;
                            rd_grant = 1'b1;
                        end else if (s_be == 4'hF) begin
                            mem_addr  = s_addr;
                            mem_write = 1'b1;
                            mem_wdata = s_wdata;
                            gnt_int   = 1'b1;
                        end else if (s_be == 4'h0) begin
                            gnt_int = 1'b1;
                        end else begin
                            mem_addr = s_addr;
                            mem_read = 1'b1;
                        end
                    end
                end
                RMW_WR: begin
                    mem_addr  = s_addr;
                    mem_write = 1'b1;
                    mem_wdata = merge;
                    gnt_int   = 1'b1;
                end
                default: ;
            endcase
        end
        m0_gnt = gnt_int && !cur_id;
        m1_gnt = gnt_int &&  cur_id;
        m0_err = err_int && !cur_id;
        m1_err = err_int &&  cur_id;
    end

    // Fairness/lock bookkeeping, RMW merge capture and registered read returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            owner     <= 1'b0;
            owned     <= 1'b0;
            lock_cnt  <= '0;
            merge     <= 32'h0;
            rmw_id    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 32'h0;
            m1_rdata  <= 32'h0;
        end else begin
            m0_rvalid <= rd_grant && !cur_id;
            m1_rvalid <= rd_grant &&  cur_id;
            if (rd_grant && !cur_id) m0_rdata <= mem_rdata;
            if (rd_grant &&  cur_id) m1_rdata <= mem_rdata;
            if (state == IDLE && sel_valid && s_partial) begin
                merge  <= merge_next;
                rmw_id <= sel_id;
            end
            if (state == IDLE && owned && !owner_req) begin
                owned    <= 1'b0;
                lock_cnt <= '0;
            end
            if (gnt_int) begin
                last <= cur_id;
                if (s_lock) begin
                    owned <= 1'b1;
                    owner <= cur_id;
                    if (owned && (owner == cur_id) && (lock_cnt < CNT_MAX)) begin
                        lock_cnt <= lock_cnt + CNT_ONE;
                    end else begin
                        lock_cnt <= CNT_ONE;
                    end
                end else begin
                    owned    <= 1'b0;
                    lock_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test of dmem_arbiter against a small
// behavioural data memory (combinational read, word write).
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;

    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_be;
    logic        m0_gnt, m0_err, m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_be;
    logic        m1_gnt, m1_err, m1_rvalid;
    logic [31:0] m1_rdata;

    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] mem [0:15];
    logic        tb_mem_we;
    logic [3:0]  tb_mem_idx;
    logic [31:0] tb_mem_val;

    int checks;
    int errors;

    dmem_arbiter #(
        .DEPTH_BYTES (64),
        .LOCK_MAX    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_be     (m0_be),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_err    (m0_err),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_be     (m1_be),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_err    (m1_err),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory with a bench-side preload port.
    always @(posedge clk) begin
        if (tb_mem_we) begin
            mem[tb_mem_idx] <= tb_mem_val;
        end else if (mem_write) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[5:2]];

    task automatic applyStimulus(input bit m, input bit req, input bit we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input bit lock);
        if (m == 1'b0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be; m0_lock = lock;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_lock = lock;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [31:0] initWord(input int i);
        case (i)
            0:       return 32'h11223344;
            1:       return 32'h55667788;
            2:       return 32'hAABBCCDD;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        tb_mem_we  = 1'b0;
        tb_mem_idx = 4'h0;
        tb_mem_val = 32'h0;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);

        // Preload memory while the arbiter is held in reset
        for (int i = 0; i < 16; i++) begin
            tb_mem_we  = 1'b1;
            tb_mem_idx = 4'(i);
            tb_mem_val = initWord(i);
            nextCycle();
        end
        tb_mem_we = 1'b0;

        // Outputs gated during reset even with live requests
        applyStimulus(0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
        applyStimulus(1, 1, 0, 32'h4, 32'h0, 4'h0, 0);
        sample();
        checkOutput("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        checkOutput("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        nextCycle();
        reset = 1'b0;

        // Reset defaults: m0 wins the first tie
        sample();
        checkOutput("rd_c0_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("rd_c0_m1_gnt", 32'(m1_gnt), 32'd0);
        checkOutput("rd_c0_mem_addr", mem_addr, 32'h0);
        checkOutput("rd_c0_m0_rvalid", 32'(m0_rvalid), 32'd0);
        checkOutput("rd_c0_m0_rdata", m0_rdata, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        sample();
        checkOutput("rd_c1_m1_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("rd_c1_mem_addr", mem_addr, 32'h4);
        checkOutput("rd_c1_m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("rd_c1_m0_rdata", m0_rdata, 32'h11223344);
        nextCycle();
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        sample();
        checkOutput("rd_c2_m1_rvalid", 32'(m1_rvalid), 32'd1);
        checkOutput("rd_c2_m1_rdata", m1_rdata, 32'h55667788);
        checkOutput("rd_c2_m0_rvalid", 32'(m0_rvalid), 32'd0);
        nextCycle();

        // Round-robin with both masters streaming full writes
        applyStimulus(0, 1, 1, 32'h10, 32'hA0A0A0A0, 4'hF, 0);
        applyStimulus(1, 1, 1, 32'h14, 32'hB1B1B1B1, 4'hF, 0);
        for (int i = 0; i < 6; i++) begin
            sample();
            checkOutput($sformatf("rr_c%0d_m0_gnt", i), 32'(m0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr_c%0d_m1_gnt", i), 32'(m1_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr_c%0d_mem_write", i), 32'(mem_write), 32'd1);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        checkOutput("rr_mem4", mem[4], 32'hA0A0A0A0);
        checkOutput("rr_mem5", mem[5], 32'hB1B1B1B1);

        // Zero-enable write: grant without touching memory
        applyStimulus(0, 1, 1, 32'hC, 32'hFFFFFFFF, 4'h0, 0);
        sample();
        checkOutput("be0_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("be0_mem_write", 32'(mem_write), 32'd0);
        checkOutput("be0_mem_read", 32'(mem_read), 32'd0);
        nextCycle();

        // Partial store by m1 racing a full write from m0
        applyStimulus(1, 1, 1, 32'h8, 32'h00001100, 4'b0010, 0);
        applyStimulus(0, 1, 1, 32'hC, 32'h12345678, 4'hF, 0);
        sample();
        checkOutput("pw_c0_mem_read", 32'(mem_read), 32'd1);
        checkOutput("pw_c0_mem_write", 32'(mem_write), 32'd0);
        checkOutput("pw_c0_mem_addr", mem_addr, 32'h8);
        checkOutput("pw_c0_m1_gnt", 32'(m1_gnt), 32'd0);
        checkOutput("pw_c0_m0_gnt", 32'(m0_gnt), 32'd0);
        nextCycle();
        sample();
        checkOutput("pw_c1_mem_write", 32'(mem_write), 32'd1);
        checkOutput("pw_c1_mem_wdata", mem_wdata, 32'hAABB11DD);
        checkOutput("pw_c1_m1_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("pw_c1_m0_gnt", 32'(m0_gnt), 32'd0);
        nextCycle();
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        sample();
        checkOutput("pw_c2_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("pw_c2_mem_wdata", mem_wdata, 32'h12345678);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        checkOutput("pw_mem2", mem[2], 32'hAABB11DD);
        checkOutput("pw_mem3", mem[3], 32'h12345678);

        // Lock bound (LOCK_MAX=4): m1 holds lock, m0 waits four grants
        applyStimulus(1, 1, 0, 32'h10, 32'h0, 4'h0, 1);
        applyStimulus(0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
        for (int i = 0; i < 6; i++) begin
            sample();
            checkOutput($sformatf("lk_c%0d_m0_gnt", i), 32'(m0_gnt), (i == 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("lk_c%0d_m1_gnt", i), 32'(m1_gnt), (i == 4) ? 32'd0 : 32'd1);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        nextCycle();

        // Error responses: misaligned read, out-of-range write, legal top word
        applyStimulus(0, 1, 0, 32'h3E, 32'h0, 4'h0, 0);
        sample();
        checkOutput("er_c0_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("er_c0_m0_err", 32'(m0_err), 32'd1);
        checkOutput("er_c0_mem_read", 32'(mem_read), 32'd0);
        checkOutput("er_c0_mem_write", 32'(mem_write), 32'd0);
        nextCycle();
        applyStimulus(0, 1, 1, 32'h40, 32'hDEADBEEF, 4'hF, 0);
        sample();
        checkOutput("er_c1_m0_rvalid", 32'(m0_rvalid), 32'd0);
        checkOutput("er_c1_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("er_c1_m0_err", 32'(m0_err), 32'd1);
        checkOutput("er_c1_mem_write", 32'(mem_write), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        applyStimulus(1, 1, 0, 32'h3C, 32'h0, 4'h0, 0);
        sample();
        checkOutput("er_c2_m1_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("er_c2_m1_err", 32'(m1_err), 32'd0);
        checkOutput("er_c2_mem_read", 32'(mem_read), 32'd1);
        nextCycle();
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        checkOutput("er_mem0", mem[0], 32'h11223344);
        checkOutput("er_mem15", mem[15], 32'h0);
        checkOutput("er_m0_rdata_hold", m0_rdata, 32'h11223344);

        // Reset asserted during the write half of a partial store
        applyStimulus(0, 1, 1, 32'h10, 32'h000000FF, 4'b0001, 0);
        sample();
        checkOutput("rr_rmw_c0_mem_read", 32'(mem_read), 32'd1);
        checkOutput("rr_rmw_c0_m0_gnt", 32'(m0_gnt), 32'd0);
        nextCycle();
        reset = 1'b1;
        sample();
        checkOutput("rr_rmw_c1_mem_write", 32'(mem_write), 32'd0);
        checkOutput("rr_rmw_c1_m0_gnt", 32'(m0_gnt), 32'd0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        applyStimulus(1, 1, 1, 32'h14, 32'h0F0F0F0F, 4'hF, 0);
        sample();
        checkOutput("rr_rmw_c2_m1_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("rr_rmw_c2_mem_wdata", mem_wdata, 32'h0F0F0F0F);
        checkOutput("rr_rmw_c2_mem_addr", mem_addr, 32'h14);
        nextCycle();
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        checkOutput("rr_rmw_mem4", mem[4], 32'hA0A0A0A0);
        checkOutput("rr_rmw_mem5", mem[5], 32'h0F0F0F0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and access sequencer in front of `data_memory`, which is byte-addressable with a combinational read and word writes. It shares the memory between the CPU load/store port (m0) and the UART boot-loader/debug port (m1). It grants requesters round-robin and supports a bounded lock for loader bursts. Partial (byte/halfword) stores become a two-cycle read-modify-write, and misaligned or out-of-range accesses are rejected with an error response.

## Interface
- `DEPTH_BYTES`, 64: memory size in bytes. Valid word addresses are 0 .. DEPTH_BYTES-4.
- `LOCK_MAX`, 16: maximum number of consecutive locked grants before lock is ignored for one arbitration.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mX_req` in 1 (X=0,1): access request. Held, with all `mX_*` inputs stable, until the cycle `mX_gnt`=1.
- `mX_we` in 1: 1 = write, 0 = read.
- `mX_addr` in 32: byte address; must be word-aligned.
- `mX_wdata` in 32: write data, lane-aligned (byte k on bits 8k+7:8k).
- `mX_be` in 4: byte enables for writes; ignored for reads.
- `mX_lock` in 1: request to keep ownership after this grant.
- `mX_gnt` out 1: access completes at the end of this cycle.
- `mX_err` out 1: valid with `mX_gnt`; the access was rejected.
- `mX_rvalid` out 1: read data valid, one cycle after a read grant.
- `mX_rdata` out 32: registered read data.
- `mem_addr` out 32: to `data_memory.addr`.
- `mem_wdata` out 32: to `write_data`.
- `mem_read` out 1: to `MemRead`.
- `mem_write` out 1: to `MemWrite`.
- `mem_rdata` in 32: from `read_data` (combinational).

## Operation
- **FSM states:**
  - IDLE (arbitrate).
  - RMW_WR (second cycle of a partial store).
- **Registers:**
  - `last` (last granted master).
  - `owner`, `owned` (lock holder).
  - `lock_cnt` (width clog2(LOCK_MAX)+1).
  - `merge` (32-bit).
  - Latched RMW master id.
- **Arbitration in IDLE:**
  - If `owned` and the owner's req=1 and `lock_cnt`<LOCK_MAX, the owner is selected.
  - Otherwise, if exactly one req is high, that master is selected.
  - Otherwise, if both are high, the master != `last` is selected.
- **Error check:** `addr[1:0]`!=0 or `addr`>DEPTH_BYTES-4 is an error.
  - Response: `gnt`=1 and `err`=1, `mem_read`=`mem_write`=0, no `rvalid`.
- **Read:** `mem_addr`=addr, `mem_read`=1, `gnt`=1. At the edge, `mem_rdata` is captured into `mX_rdata` and `mX_rvalid`=1 for the next cycle.
- **Full write (be=1111):** `mem_write`=1, `mem_wdata`=wdata, `gnt`=1.
- **Zero-enable write (be=0000):** `gnt`=1, no memory access.
- **Partial write (any other be):**
  - IDLE cycle: `mem_read`=1, `gnt`=0. At the edge, `merge` = per byte lane, wdata if be[k] else `mem_rdata`. Go to RMW_WR.
  - RMW_WR cycle: `mem_write`=1, `mem_wdata`=`merge`, `gnt`=1 to the latched master. Go to IDLE.
  - The other master's requests are not granted during RMW_WR.
- **At every gnt edge:**
  - `last`<=granted id.
  - If granted `lock`=1, then `owned`<=1, `owner`<=id, and `lock_cnt`<=`lock_cnt`+1 (or 1 if the owner changed).
  - Else `owned`<=0 and `lock_cnt`<=0.
- **Lock release:**
  - Owner's req low in IDLE: clears `owned` and `lock_cnt` at that edge.
  - `lock_cnt`==LOCK_MAX: lock is ignored for that arbitration, so round-robin applies. Whichever master wins, the next grant reloads `lock_cnt` (1 or 0).
- **Output gating:** `gnt`, `err`, `mem_read`, `mem_write` are combinational from state and inputs, and are forced to 0 while `reset`=1.

## Timing
- **Reset values:** state=IDLE, `last`=1 (m0 wins first tie), `owned`=0, `lock_cnt`=0, `merge`=0, `mX_rvalid`=0, `mX_rdata`=0. All combinational outputs are 0 during reset.
- **Reset mid-RMW:** returns to IDLE, no write issued, `merge` discarded, no gnt.
- **Latency:**
  - Read: `gnt` in the request cycle, `rvalid` and `rdata` the next cycle. Back-to-back reads give one `rvalid` per cycle.
  - Full or zero-enable write, and error response: 1 cycle.
  - Partial write: 2 cycles.
- **Simultaneous requests:** the loser waits at least 1 cycle. The loser of a partial-write race waits 2 cycles.
- `rvalid` is a one-cycle pulse per granted read. `rdata` holds its value until the next granted read for that master.

## Test plan
- **Reset defaults:** after reset, both req=1 reading addr 0 and 4 (mem=0x11223344 at 0) → m0 gnt cycle 0, `m0_rdata`=0x11223344 with rvalid cycle 1; m1 gnt cycle 1.
- **Round-robin:** both masters hold req for 6 cycles of full writes → gnts alternate m0, m1, m0, …, never the same master twice in a row.
- **Partial store:** mem[8]=0xAABBCCDD, m1 writes wdata=0x00001100, be=0010 → `mem_read` cycle 0, `mem_write` cycle 1 with 0xAABB11DD, gnt only in cycle 1; a concurrent m0 request is granted in cycle 2.
- **Lock bound:** LOCK_MAX=4, m1 req+lock continuous, m0 req from cycle 0 → m1 granted cycles 0-3, m0 cycle 4, m1 cycle 5.
- **Errors:** addr=0x3E or addr=0x40 (DEPTH 64) → `gnt`=`err`=1, `mem_read`=`mem_write`=0, no `rvalid`; memory contents unchanged.
- **Reset during RMW_WR:** assert reset in cycle 1 of a partial write → `mem_write` 0, no gnt, memory unchanged, state IDLE after release.
